// File: rtl/instruction_fetch.sv
// Fetch stage: reads 1- or 2-byte instructions at pc_in over a req/ack port.
// Presents opcode/imm to control under valid/ready and strobes the PC once per byte.
module instruction_fetch #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_enable,
    input  logic              flush,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir_opcode,
    output logic [DATA_W-1:0] ir_imm,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic              fetch_err
);

    localparam int WAIT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        REQ_OP,
        STEP,
        REQ_IMM,
        HOLD,
        ERR
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_req_q;
    logic              pc_en_q;
    logic              pc_en_d;
    logic              ld_op;
    logic              ld_imm;
    logic              req_d;
    logic              req_entry;
    logic              timeout;

    assign timeout   = (wait_cnt == WAIT_W'(TIMEOUT - 1));
    assign mem_addr  = pc_in;
    assign mem_req   = mem_req_q;
    // A branch load on the same edge must never be combined with an increment
    assign pc_enable = pc_en_q & ~flush;
    assign ir_valid  = (state_q == HOLD);
    assign fetch_err = (state_q == ERR);

    always_comb begin
        state_d = state_q;
        pc_en_d = 1'b0;
        ld_op   = 1'b0;
        ld_imm  = 1'b0;
        unique case (state_q)
            IDLE: state_d = REQ_OP;
            REQ_OP: begin
                if (flush) begin
                    state_d = REQ_OP;
                end else if (mem_ack) begin
                    ld_op   = 1'b1;
                    pc_en_d = 1'b1;
                    state_d = mem_rdata[DATA_W-1] ? STEP : HOLD;
                end else if (timeout) begin
                    state_d = ERR;
                end
            end
            STEP: state_d = flush ? REQ_OP : REQ_IMM;
            REQ_IMM: begin
                if (flush) begin
                    state_d = REQ_OP;
                end else if (mem_ack) begin
                    ld_imm  = 1'b1;
                    pc_en_d = 1'b1;
                    state_d = HOLD;
                end else if (timeout) begin
                    state_d = ERR;
                end
            end
            HOLD: begin
                if (flush || ir_ready) state_d = REQ_OP;
            end
            ERR: state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    assign req_d     = (state_d == REQ_OP) || (state_d == REQ_IMM);
    // A flush restarts the opcode request even when already in REQ_OP
    assign req_entry = req_d && ((state_d != state_q) || flush);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            pc_en_q   <= 1'b0;
            wait_cnt  <= '0;
            ir_opcode <= '0;
            ir_imm    <= '0;
        end else begin
            state_q   <= state_d;
            mem_req_q <= req_d;
            pc_en_q   <= pc_en_d;
            if (req_entry) begin
                wait_cnt <= '0;
            end else if (mem_req_q && !mem_ack) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (ld_op) begin
                ir_opcode <= mem_rdata;
                if (!mem_rdata[DATA_W-1]) ir_imm <= '0;
            end
            if (ld_imm) ir_imm <= mem_rdata;
        end
    end

endmodule
